esn_run_ctrl: RTL and testbench
===============================

Name: esn_run_ctrl

Overview:
Run sequencer for the ESN pipeline (reservoir plus readout). It replaces the fixed reset delay line and the ad-hoc reset-pulse logic with one FSM. The FSM issues a timed reservoir reset, then a programmable-delay readout reset. It then trains for a programmed number of epochs with readout output disabled, and finally enables readout output (ce) for a programmed number of valid estimates. Epochs are counted from wraps of the reservoir's train-data address; estimates are counted from the readout's data_valid.

Parameters:
ADDR_W, 6, width of reservoir data address; one epoch is one full address sweep.
RST_CYCLES, 6, cycles the reservoir reset is held low.
EPOCH_W, 8, width of the epoch count and its config.
EVAL_W, 16, width of the estimate count and its config.
TIMEOUT, 1024, max cycles between data_valid pulses in RUN before an error.

Ports:
clk  input  1  system clock
rst_N  input  1  asynchronous active-low reset; all state cleared immediately
start  input  1  one-cycle pulse; honoured only in IDLE, DONE or ERR
abort  input  1  level; returns the FSM to IDLE from any state on the next edge
cfg_epochs  input  EPOCH_W  training epochs; sampled on start; 0 skips TRAIN
cfg_rdout_dly  input  4  cycles from reservoir reset release to readout reset release; sampled on start
cfg_n_eval  input  EVAL_W  estimates to collect; sampled on start; 0 means run until abort
data_addr  input  ADDR_W  reservoir train-data address
rdout_valid  input  1  readout data_valid
res_rst_N  output  1  reservoir reset, active-low
rdout_rst_N  output  1  readout reset, active-low
rdout_ce  output  1  readout output enable
busy  output  1  high in every state except IDLE, DONE, ERR
state_o  output  3  current state encoding
epoch_cnt  output  EPOCH_W  completed epochs this run
eval_cnt  output  EVAL_W  valid estimates this run
done  output  1  one-cycle pulse on entry to DONE
err  output  1  level; high in ERR

Behaviour:
- Async reset: state=IDLE; res_rst_N=0; rdout_rst_N=0; rdout_ce=0; counters=0; done=0; err=0. All outputs are registered.
- States: IDLE=0, RES_RST=1, RDOUT_DLY=2, TRAIN=3, RUN=4, DONE=5, ERR=6. Encodings 7 and others decode to IDLE.
- IDLE: both resets held low, ce=0. On start, latch the cfg values, clear the counters, go to RES_RST.
- RES_RST: res_rst_N=0, rdout_rst_N=0 for exactly RST_CYCLES cycles. Then go to RDOUT_DLY; res_rst_N=1 from the first RDOUT_DLY cycle.
- RDOUT_DLY: rdout_rst_N stays 0 for cfg_rdout_dly cycles, then goes 1. A value of 0 releases it in the same cycle as res_rst_N, and the state lasts 1 cycle. Exit goes to TRAIN, or to RUN if cfg_epochs==0.
- Wrap detect: register data_addr as addr_q. wrap = (addr_q == 2^ADDR_W-1) && (data_addr == 0). It is evaluated only in TRAIN and RUN. addr_q is updated every cycle, so a wrap that straddles a state change is still seen.
- TRAIN: ce=0. Each wrap increments epoch_cnt. When epoch_cnt reaches cfg_epochs (the increment cycle), the next state is RUN. epoch_cnt saturates and never wraps.
- RUN: ce=1. Each rdout_valid high cycle increments eval_cnt, saturating at all-ones.
  - When the count reaches cfg_n_eval (nonzero), go to DONE on the next edge.
  - A watchdog counts cycles since entry or since the last rdout_valid. When it reaches TIMEOUT, go to ERR.
  - Wraps continue to increment epoch_cnt, with saturation.
- DONE: ce=0. Resets stay released, so the trained weights are preserved. done pulses for 1 cycle. start restarts from RES_RST.
- ERR: ce=0, err=1, rdout_rst_N=0, res_rst_N stays 1. Left only by start (to RES_RST) or abort (to IDLE).
- Priority per edge: abort > start > internal transitions. start is ignored while busy.
- Reset asserted mid-run: immediate IDLE with all outputs at reset values; the latched config is discarded.
- Config inputs may change while busy with no effect.

Decomposition:
- Package esn_ctrl_pkg holds the state enum/localparams (IDLE..ERR) and the default TIMEOUT and RST_CYCLES constants. It is shared with the bench for state_o decoding.
- One sub-module, esn_wrap_det: ADDR_W-parameterised address register plus wrap pulse. It is reused by the bench monitors.

Test Plan:
- Reset then start with cfg_epochs=2, cfg_rdout_dly=3, cfg_n_eval=5, addr sweeping 0..63 → res_rst_N low for 6 cycles; rdout_rst_N rises 3 cycles after res_rst_N; ce rises the cycle after the 2nd wrap; done pulses after the 5th valid; eval_cnt=5.
- cfg_epochs=0, cfg_rdout_dly=0 → both resets release in the same cycle; TRAIN is skipped; ce=1 on the cycle after release.
- In RUN, hold rdout_valid low for 1024 cycles → state_o=6, err=1, ce=0, rdout_rst_N=0. A following start re-enters RES_RST and clears err.
- abort and start asserted together in TRAIN → IDLE; both resets low; counters are not cleared until the next start.
- rst_N dropped asynchronously mid-RUN (between edges) → outputs reach reset values before the next clk edge.
- cfg_n_eval=0, 70000 valids → eval_cnt saturates at 0xFFFF; no DONE until abort; addr jump 62→0 does not count as an epoch.

Source files
------------

// File: rtl/esn_ctrl_pkg.sv
// Shared definitions for the ESN run sequencer: state encoding and default timing constants.
package esn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RES_RST   = 3'd1,
    RDOUT_DLY = 3'd2,
    TRAIN     = 3'd3,
    RUN       = 3'd4,
    DONE      = 3'd5,
    ERR       = 3'd6
  } state_t;

  localparam int DEF_TIMEOUT    = 1024;
  localparam int DEF_RST_CYCLES = 6;

  function automatic logic is_busy(input state_t s);
    return (s == RES_RST) || (s == RDOUT_DLY) || (s == TRAIN) || (s == RUN);
  endfunction

endpackage

// File: rtl/esn_wrap_det.sv
// Registers the reservoir train-data address and flags the top-to-zero wrap that ends an epoch.
module esn_wrap_det #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= addr;
  end

  // Only a genuine last-to-first step counts; jumps from other addresses to zero do not.
  assign wrap = (addr_q == '1) && (addr == '0);

endmodule

// File: rtl/esn_run_ctrl.sv
// ESN run sequencer: timed reservoir reset, delayed readout reset, epoch training, then
// readout-enabled evaluation with a data_valid watchdog.
module esn_run_ctrl
  import esn_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int EPOCH_W    = 8,
  parameter int EVAL_W     = 16,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_N,
  input  logic               start,
  input  logic               abort,
  input  logic [EPOCH_W-1:0] cfg_epochs,
  input  logic [3:0]         cfg_rdout_dly,
  input  logic [EVAL_W-1:0]  cfg_n_eval,
  input  logic [ADDR_W-1:0]  data_addr,
  input  logic               rdout_valid,
  output logic               res_rst_N,
  output logic               rdout_rst_N,
  output logic               rdout_ce,
  output logic               busy,
  output logic [2:0]         state_o,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic [EVAL_W-1:0]  eval_cnt,
  output logic               done,
  output logic               err
);

  localparam int TMR_W = ($clog2(RST_CYCLES) > 4) ? $clog2(RST_CYCLES) : 4;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_t             state, state_n;
  logic [TMR_W-1:0]   tmr, tmr_n;
  logic [WD_W-1:0]    wd, wd_n;
  logic [EPOCH_W-1:0] epochs_q, ep_inc;
  logic [3:0]         dly_q;
  logic [EVAL_W-1:0]  n_eval_q, ev_inc;
  logic               wrap, start_run;

  esn_wrap_det #(.ADDR_W(ADDR_W)) u_wrap (
    .clk   (clk),
    .rst_n (rst_N),
    .addr  (data_addr),
    .wrap  (wrap)
  );

  always_comb begin
    ep_inc  = (epoch_cnt == '1) ? epoch_cnt : epoch_cnt + 1'b1;
    ev_inc  = (eval_cnt == '1) ? eval_cnt : eval_cnt + 1'b1;
    state_n = state;
    case (state)
      IDLE:      if (start) state_n = RES_RST;
      RES_RST:   if (tmr == TMR_W'(RST_CYCLES - 1)) state_n = RDOUT_DLY;
      RDOUT_DLY: if (tmr == TMR_W'(dly_q)) state_n = (epochs_q == '0) ? RUN : TRAIN;
      TRAIN:     if (wrap && (ep_inc == epochs_q)) state_n = RUN;
      RUN: begin
        if (rdout_valid) begin
          if ((n_eval_q != '0) && (ev_inc == n_eval_q)) state_n = DONE;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          state_n = ERR;
        end
      end
      DONE, ERR: if (start) state_n = RES_RST;
      default:   state_n = start ? RES_RST : IDLE;
    endcase
    if (abort) state_n = IDLE;

    // Timers restart on every state change; the watchdog also restarts on each valid.
    tmr_n     = (state_n != state) ? '0 : tmr + 1'b1;
    wd_n      = ((state_n != state) || rdout_valid) ? '0 : wd + 1'b1;
    start_run = (state_n == RES_RST) && (state != RES_RST);
  end

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state       <= IDLE;
      tmr         <= '0;
      wd          <= '0;
      epochs_q    <= '0;
      dly_q       <= '0;
      n_eval_q    <= '0;
      epoch_cnt   <= '0;
      eval_cnt    <= '0;
      res_rst_N   <= 1'b0;
      rdout_rst_N <= 1'b0;
      rdout_ce    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
      wd    <= wd_n;
      if (start_run) begin
        epochs_q  <= cfg_epochs;
        dly_q     <= cfg_rdout_dly;
        n_eval_q  <= cfg_n_eval;
        epoch_cnt <= '0;
        eval_cnt  <= '0;
      end else begin
        if (wrap && ((state == TRAIN) || (state == RUN))) epoch_cnt <= ep_inc;
        if (rdout_valid && (state == RUN))                 eval_cnt  <= ev_inc;
      end
      // Outputs follow the next state so they line up with state_o.
      res_rst_N   <= (state_n == RDOUT_DLY) || (state_n == TRAIN) || (state_n == RUN) ||
                     (state_n == DONE) || (state_n == ERR);
      rdout_rst_N <= (state_n == RDOUT_DLY) ? (tmr_n == TMR_W'(dly_q)) :
                     ((state_n == TRAIN) || (state_n == RUN) || (state_n == DONE));
      rdout_ce    <= (state_n == RUN);
      busy        <= is_busy(state_n);
      done        <= (state_n == DONE) && (state != DONE);
      err         <= (state_n == ERR);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_esn_run_ctrl.sv
// Directed bench for esn_run_ctrl: a vector table for a short run plus hand sequences for corners.
module tb_esn_run_ctrl;
  import esn_ctrl_pkg::*;

  localparam int ADDR_W = 6, EPOCH_W = 8, EVAL_W = 16;

  logic               clk = 1'b0, rst_N = 1'b0, start = 1'b0, abort = 1'b0, rdout_valid = 1'b0;
  logic [EPOCH_W-1:0] cfg_epochs = '0;
  logic [3:0]         cfg_rdout_dly = '0;
  logic [EVAL_W-1:0]  cfg_n_eval = '0;
  logic [ADDR_W-1:0]  data_addr = '0, sweep = '0;
  logic               res_rst_N, rdout_rst_N, rdout_ce, busy, done, err, mon_wrap, pw;
  logic [2:0]         state_o;
  logic [EPOCH_W-1:0] epoch_cnt;
  logic [EVAL_W-1:0]  eval_cnt;
  int n_chk = 0, n_fail = 0;

  typedef struct {int s, a, ad, v, st, res, rd, ce, dn, ep, ev;} vec_t;
  vec_t tbl[16];

  esn_run_ctrl #(.ADDR_W(ADDR_W), .RST_CYCLES(6), .EPOCH_W(EPOCH_W), .EVAL_W(EVAL_W),
                 .TIMEOUT(1024)) dut (
    .clk(clk), .rst_N(rst_N), .start(start), .abort(abort), .cfg_epochs(cfg_epochs),
    .cfg_rdout_dly(cfg_rdout_dly), .cfg_n_eval(cfg_n_eval), .data_addr(data_addr),
    .rdout_valid(rdout_valid), .res_rst_N(res_rst_N), .rdout_rst_N(rdout_rst_N),
    .rdout_ce(rdout_ce), .busy(busy), .state_o(state_o), .epoch_cnt(epoch_cnt),
    .eval_cnt(eval_cnt), .done(done), .err(err)
  );

  esn_wrap_det #(.ADDR_W(ADDR_W)) mon (.clk(clk), .rst_n(rst_N), .addr(data_addr), .wrap(mon_wrap));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Sweeping-address cycle; pw records whether the cycle just ended carried a wrap.
  task automatic tick(input logic v);
    data_addr = sweep; rdout_valid = v; #1;
    pw = mon_wrap;
    @(posedge clk); #1;
    sweep = sweep + 1'b1;
  endtask

  task automatic do_reset();
    rst_N = 1'b0; start = 1'b0; abort = 1'b0; rdout_valid = 1'b0;
    step(); step();
    rst_N = 1'b1;
    step();
  endtask

  task automatic chk_outs(input string t, input int st, input int res, input int rd, input int ce,
                          input int dn, input int ep, input int ev);
    chk({t, ".state"}, int'(state_o), st);
    chk({t, ".res_rst_N"}, int'(res_rst_N), res);
    chk({t, ".rdout_rst_N"}, int'(rdout_rst_N), rd);
    chk({t, ".ce"}, int'(rdout_ce), ce);
    chk({t, ".done"}, int'(done), dn);
    chk({t, ".epoch_cnt"}, int'(epoch_cnt), ep);
    chk({t, ".eval_cnt"}, int'(eval_cnt), ev);
    chk({t, ".busy"}, int'(busy), (st >= 1 && st <= 4) ? 1 : 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, seen_done, left_run;

    // Short run: epochs=1, dly=1, n_eval=2, wraps forced with 63->0 steps.
    tbl[0] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 1; i <= 5; i++) tbl[i] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 0,  0, 0, 2, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0,  0, 0, 2, 1, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 63, 0, 3, 1, 1, 0, 0, 0, 0};
    tbl[9]  = '{0, 0,  0, 0, 4, 1, 1, 1, 0, 1, 0};
    tbl[10] = '{0, 0,  0, 1, 4, 1, 1, 1, 0, 1, 1};
    tbl[11] = '{0, 0, 63, 0, 4, 1, 1, 1, 0, 1, 1};
    tbl[12] = '{0, 0,  0, 1, 5, 1, 1, 0, 1, 2, 2};
    tbl[13] = '{0, 0,  0, 0, 5, 1, 1, 0, 0, 2, 2};
    tbl[14] = '{0, 0,  0, 1, 5, 1, 1, 0, 0, 2, 2};
    tbl[15] = '{0, 1,  0, 0, 0, 0, 0, 0, 0, 2, 2};

    cfg_epochs = 8'd1; cfg_rdout_dly = 4'd1; cfg_n_eval = 16'd2;
    step();
    chk_outs("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.err", int'(err), 0);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      start = 1'(tbl[i].s); abort = 1'(tbl[i].a);
      data_addr = 6'(tbl[i].ad); rdout_valid = 1'(tbl[i].v);
      step();
      chk_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].res, tbl[i].rd, tbl[i].ce,
               tbl[i].dn, tbl[i].ep, tbl[i].ev);
    end
    abort = 1'b0;

    // Full sweep run: epochs=2, dly=3, n_eval=5.
    do_reset();
    cfg_epochs = 8'd2; cfg_rdout_dly = 4'd3; cfg_n_eval = 16'd5; sweep = '0;
    start = 1'b1; tick(1'b0); start = 1'b0;
    n = 0;
    while (!res_rst_N && n < 20) begin n++; tick(1'b0); end
    chk("sweep.res_low_cycles", n, 6);
    n = 0;
    while (!rdout_rst_N && n < 20) begin n++; tick(1'b0); end
    chk("sweep.rdout_delay", n, 3);
    n = 0;
    while (!rdout_ce && n < 400) begin n++; tick(1'b0); end
    chk("sweep.ce_rise", int'(rdout_ce), 1);
    chk("sweep.ce_after_wrap", int'(pw), 1);
    chk("sweep.epochs", int'(epoch_cnt), 2);
    tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b1);
    chk("sweep.ev3", int'(eval_cnt), 3);
    tick(1'b1);
    chk("sweep.ev4", int'(eval_cnt), 4);
    chk("sweep.run4", int'(state_o), int'(RUN));
    tick(1'b1);
    chk("sweep.done_state", int'(state_o), int'(DONE));
    chk("sweep.done_pulse", int'(done), 1);
    chk("sweep.ev5", int'(eval_cnt), 5);
    chk("sweep.ce_off", int'(rdout_ce), 0);
    tick(1'b0);
    chk("sweep.done_once", int'(done), 0);
    chk("sweep.res_kept", int'(res_rst_N), 1);

    // epochs=0, dly=0 restarted from DONE: joint release, TRAIN skipped.
    data_addr = 6'd10; rdout_valid = 1'b0;
    cfg_epochs = 8'd0; cfg_rdout_dly = 4'd0; cfg_n_eval = 16'd3;
    start = 1'b1; step(); start = 1'b0;
    repeat (5) step();
    chk("zero.res_still_low", int'(res_rst_N), 0);
    step();
    chk_outs("zero.release", int'(RDOUT_DLY), 1, 1, 0, 0, 0, 0);
    step();
    chk("zero.run", int'(state_o), int'(RUN));
    chk("zero.ce", int'(rdout_ce), 1);

    // Watchdog: 1024 quiet RUN cycles lead to ERR.
    repeat (1023) step();
    chk("wd.still_run", int'(state_o), int'(RUN));
    step();
    chk("wd.err_state", int'(state_o), int'(ERR));
    chk("wd.err", int'(err), 1);
    chk("wd.ce", int'(rdout_ce), 0);
    chk("wd.rdout_rst", int'(rdout_rst_N), 0);
    chk("wd.res_rst", int'(res_rst_N), 1);
    chk("wd.busy", int'(busy), 0);
    cfg_epochs = 8'd3;
    start = 1'b1; step(); start = 1'b0;
    chk("wd.restart", int'(state_o), int'(RES_RST));
    chk("wd.err_clr", int'(err), 0);
    chk("wd.res_low", int'(res_rst_N), 0);

    // abort together with start in TRAIN.
    repeat (6) step();
    step();
    chk("abort.train", int'(state_o), int'(TRAIN));
    data_addr = 6'd63; step(); data_addr = 6'd0; step();
    chk("abort.ep1", int'(epoch_cnt), 1);
    chk("abort.still_train", int'(state_o), int'(TRAIN));
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk_outs("abort.idle", int'(IDLE), 0, 0, 0, 0, 1, 0);
    step();
    chk("abort.idle_hold", int'(state_o), int'(IDLE));
    cfg_epochs = 8'd0; cfg_rdout_dly = 4'd0; cfg_n_eval = 16'd0;
    start = 1'b1; step(); start = 1'b0;
    chk("abort.restart", int'(state_o), int'(RES_RST));
    chk("abort.ep_clr", int'(epoch_cnt), 0);

    // Asynchronous reset between edges in RUN.
    repeat (7) step();
    chk("arst.run", int'(state_o), int'(RUN));
    rdout_valid = 1'b1; step(); rdout_valid = 1'b0;
    chk("arst.ev1", int'(eval_cnt), 1);
    #2 rst_N = 1'b0;
    #1;
    chk_outs("arst", int'(IDLE), 0, 0, 0, 0, 0, 0);
    chk("arst.err", int'(err), 0);
    step();
    rst_N = 1'b1;
    step();
    chk("arst.idle_after", int'(state_o), int'(IDLE));

    // n_eval=0: run until abort, eval saturates, 62->0 is not an epoch.
    start = 1'b1; step(); start = 1'b0;
    repeat (7) step();
    chk("sat.run", int'(state_o), int'(RUN));
    rdout_valid = 1'b1;
    data_addr = 6'd62; step(); data_addr = 6'd0; step();
    chk("sat.no_fake_epoch", int'(epoch_cnt), 0);
    seen_done = 0; left_run = 0;
    for (int i = 0; i < 70000; i++) begin
      step();
      if (done) seen_done++;
      if (state_o != 3'(RUN)) left_run++;
    end
    data_addr = 6'd63; step(); data_addr = 6'd0; step();
    chk("sat.real_epoch", int'(epoch_cnt), 1);
    chk("sat.eval_sat", int'(eval_cnt), 65535);
    chk("sat.no_done", seen_done, 0);
    chk("sat.stayed_run", left_run, 0);
    rdout_valid = 1'b0; abort = 1'b1; step(); abort = 1'b0;
    chk("sat.abort_idle", int'(state_o), int'(IDLE));
    chk("sat.ev_kept", int'(eval_cnt), 65535);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
